// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: shared dual-port word RAM plus MMIO page for the CPU's
// fetch (pc) and load/store (ldst) ports. Both ports have a 1-cycle read latency.
// Optional macro MEM_FWD_EN: a same-cycle ldst write and pc read of one RAM word
// forwards the write data to the fetch port (write-first). Without the macro,
// the fetch port returns the old word (read-first).
module cpu_mem_responder #(
   parameter int           RAM_WORDS = 4096,
   parameter logic [3:0]   MMIO_PAGE = 4'hF,
   parameter int           LED_W     = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      i_pc_addr,
   input  logic             i_pc_rd,
   output logic [15:0]      o_pc_rddata,
   input  logic [15:0]      i_ldst_addr,
   input  logic             i_ldst_rd,
   input  logic             i_ldst_wr,
   input  logic [15:0]      i_ldst_wrdata,
   output logic [15:0]      o_ldst_rddata,
   input  logic [LED_W-1:0] i_sw,
   output logic [LED_W-1:0] o_ledr
);

   localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   localparam logic [11:0] A_LEDR   = 12'h000;
   localparam logic [11:0] A_SW     = 12'h002;
   localparam logic [11:0] A_CYCLES = 12'h004;

   logic [15:0]      r_ram [RAM_WORDS];
   logic [15:0]      r_pc_rddata;
   logic [15:0]      r_ldst_rddata;
   logic [LED_W-1:0] r_ledr;
   logic [LED_W-1:0] r_sw_meta;
   logic [LED_W-1:0] r_sw_sync;
   logic [15:0]      r_cycles;

   logic [14:0]      w_pc_word;
   logic [14:0]      w_ldst_word;
   logic [IDX_W-1:0] w_pc_idx;
   logic [IDX_W-1:0] w_ldst_idx;
   logic             w_pc_mmio;
   logic             w_ldst_mmio;
   logic             w_ram_we;
   logic             w_led_we;
   logic [15:0]      w_mmio_rd;
   logic [15:0]      w_pc_ram_rd;

   // Address decode: bit 0 dropped, word index wraps modulo RAM_WORDS
   assign w_pc_word   = i_pc_addr[15:1];
   assign w_ldst_word = i_ldst_addr[15:1];
   assign w_pc_idx    = IDX_W'(w_pc_word % 15'(RAM_WORDS));
   assign w_ldst_idx  = IDX_W'(w_ldst_word % 15'(RAM_WORDS));
   assign w_pc_mmio   = (i_pc_addr[15:12] == MMIO_PAGE);
   assign w_ldst_mmio = (i_ldst_addr[15:12] == MMIO_PAGE);

   // Writes are suppressed while reset is high so a cancelled access leaves no trace
   assign w_ram_we = i_ldst_wr && !w_ldst_mmio && !reset;
   assign w_led_we = i_ldst_wr && w_ldst_mmio && (i_ldst_addr[11:0] == A_LEDR);

`ifdef MEM_FWD_EN
   // Write-first: a colliding store is visible to the fetch in the same cycle
   assign w_pc_ram_rd = (i_ldst_wr && !w_ldst_mmio && (w_pc_idx == w_ldst_idx))
                        ? i_ldst_wrdata : r_ram[w_pc_idx];
`else
   // Read-first: the fetch sees the word as it was before this edge
   assign w_pc_ram_rd = r_ram[w_pc_idx];
`endif

   // MMIO read mux; unmapped addresses read zero
   always_comb begin
      w_mmio_rd = 16'h0000;
      case (i_ldst_addr[11:0])
         A_LEDR:   w_mmio_rd = 16'(r_ledr);
         A_SW:     w_mmio_rd = 16'(r_sw_sync);
         A_CYCLES: w_mmio_rd = r_cycles;
         default:  w_mmio_rd = 16'h0000;
      endcase
   end

   // RAM array write; contents are not cleared by reset
   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ldst_idx] <= i_ldst_wrdata;
   end

   // Fetch read data register; MMIO page fetches return zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_pc_rddata <= 16'h0000;
      else if (i_pc_rd) r_pc_rddata <= w_pc_mmio ? 16'h0000 : w_pc_ram_rd;
   end

   // Load read data register; a store in the same cycle wins and the data holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_ldst_rddata <= 16'h0000;
      else if (i_ldst_rd && !i_ldst_wr) r_ldst_rddata <= w_ldst_mmio ? w_mmio_rd : r_ram[w_ldst_idx];
   end

   // LED register, switch synchroniser and free-running cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ledr    <= '0;
         r_sw_meta <= '0;
         r_sw_sync <= '0;
         r_cycles  <= 16'h0000;
      end else begin
         if (w_led_we) r_ledr <= i_ldst_wrdata[LED_W-1:0];
         r_sw_meta <= i_sw;
         r_sw_sync <= r_sw_meta;
         r_cycles  <= r_cycles + 16'h0001;
      end
   end

   assign o_pc_rddata   = r_pc_rddata;
   assign o_ldst_rddata = r_ldst_rddata;
   assign o_ledr        = r_ledr;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: vector table plus hand sequences for
// switch synchroniser, counter, reset and wrap corner cases.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] i_pc_addr;
   logic        i_pc_rd;
   logic [15:0] o_pc_rddata;
   logic [15:0] i_ldst_addr;
   logic        i_ldst_rd;
   logic        i_ldst_wr;
   logic [15:0] i_ldst_wrdata;
   logic [15:0] o_ldst_rddata;
   logic [9:0]  i_sw;
   logic [9:0]  o_ledr;

   int errors = 0;
   int checks = 0;

   cpu_mem_responder dut (
      .clk(clk), .reset(reset),
      .i_pc_addr(i_pc_addr), .i_pc_rd(i_pc_rd), .o_pc_rddata(o_pc_rddata),
      .i_ldst_addr(i_ldst_addr), .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr),
      .i_ldst_wrdata(i_ldst_wrdata), .o_ldst_rddata(o_ldst_rddata),
      .i_sw(i_sw), .o_ledr(o_ledr)
   );

   always #5 clk = ~clk;

`ifdef MEM_FWD_EN
   localparam logic [15:0] FWD_V = 16'h1234;
`else
   localparam logic [15:0] FWD_V = 16'h0000;
`endif

   typedef struct {
      logic [15:0] pc_addr;
      logic        pc_rd;
      logic [15:0] ld_addr;
      logic        rd;
      logic        wr;
      logic [15:0] wd;
      logic [15:0] e_pc;
      logic [15:0] e_ld;
      logic [9:0]  e_led;
   } vec_t;

   vec_t tv[20];

   function automatic vec_t mk(logic [15:0] pa, logic pr, logic [15:0] la, logic r, logic w,
                               logic [15:0] d, logic [15:0] ep, logic [15:0] el, logic [9:0] ed);
      vec_t v;
      v.pc_addr = pa; v.pc_rd = pr; v.ld_addr = la; v.rd = r; v.wr = w; v.wd = d;
      v.e_pc = ep; v.e_ld = el; v.e_led = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      i_pc_rd = 1'b0; i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [15:0] a);
      idle(); i_ldst_addr = a; i_ldst_rd = 1'b1;
   endtask

   task automatic st(input logic [15:0] a, input logic [15:0] d);
      idle(); i_ldst_addr = a; i_ldst_wr = 1'b1; i_ldst_wrdata = d;
   endtask

   logic [15:0] c0;

   initial begin
      //       pc_addr  prd  ld_addr  rd  wr  wdata     e_pc      e_ld      e_led
      tv[0]  = mk(16'h0000,0, 16'h0010,0,1, 16'hBEEF, 16'h0000, 16'h0000, 10'h000);
      tv[1]  = mk(16'h0000,0, 16'h0010,1,0, 16'h0000, 16'h0000, 16'hBEEF, 10'h000);
      tv[2]  = mk(16'h0000,0, 16'h0010,0,0, 16'h0000, 16'h0000, 16'hBEEF, 10'h000);
      tv[3]  = mk(16'h0020,1, 16'h0020,0,1, 16'h1234, FWD_V,    16'hBEEF, 10'h000);
      tv[4]  = mk(16'h0020,1, 16'h0000,0,0, 16'h0000, 16'h1234, 16'hBEEF, 10'h000);
      tv[5]  = mk(16'h0000,0, 16'hF000,0,1, 16'h03FF, 16'h1234, 16'hBEEF, 10'h3FF);
      tv[6]  = mk(16'h0000,0, 16'hF000,1,0, 16'h0000, 16'h1234, 16'h03FF, 10'h3FF);
      tv[7]  = mk(16'h0000,0, 16'h0030,1,1, 16'h7777, 16'h1234, 16'h03FF, 10'h3FF);
      tv[8]  = mk(16'h0030,1, 16'h0000,0,0, 16'h0000, 16'h7777, 16'h03FF, 10'h3FF);
      tv[9]  = mk(16'h0000,0, 16'h0031,1,0, 16'h0000, 16'h7777, 16'h7777, 10'h3FF);
      tv[10] = mk(16'h0000,0, 16'h2010,0,1, 16'hABCD, 16'h7777, 16'h7777, 10'h3FF);
      tv[11] = mk(16'h0020,1, 16'h0010,1,0, 16'h0000, 16'h1234, 16'hABCD, 10'h3FF);
      tv[12] = mk(16'hF002,1, 16'h0000,0,0, 16'h0000, 16'h0000, 16'hABCD, 10'h3FF);
      tv[13] = mk(16'h0000,0, 16'hF008,1,0, 16'h0000, 16'h0000, 16'h0000, 10'h3FF);
      tv[14] = mk(16'h0000,0, 16'hF002,0,1, 16'h0001, 16'h0000, 16'h0000, 10'h3FF);
      tv[15] = mk(16'h0000,0, 16'hF000,1,0, 16'h0000, 16'h0000, 16'h03FF, 10'h3FF);
      tv[16] = mk(16'h0000,0, 16'hF000,0,1, 16'hFC00, 16'h0000, 16'h03FF, 10'h000);
      tv[17] = mk(16'h0000,0, 16'hF000,1,0, 16'h0000, 16'h0000, 16'h0000, 10'h000);
      tv[18] = mk(16'h0000,0, 16'hF000,0,1, 16'h0155, 16'h0000, 16'h0000, 10'h155);
      tv[19] = mk(16'h0000,0, 16'hF000,1,0, 16'h0000, 16'h0000, 16'h0155, 10'h155);

      reset = 1'b1; i_pc_addr = 16'h0; i_ldst_addr = 16'h0; i_ldst_wrdata = 16'h0;
      i_sw = 10'h0; idle();
      #1;
      chk("por_pc",  o_pc_rddata, 16'h0000);
      chk("por_ld",  o_ldst_rddata, 16'h0000);
      chk("por_led", 16'(o_ledr), 16'h0000);
      step(); step();
      reset = 1'b0;

      foreach (tv[i]) begin
         i_pc_addr = tv[i].pc_addr; i_pc_rd = tv[i].pc_rd;
         i_ldst_addr = tv[i].ld_addr; i_ldst_rd = tv[i].rd; i_ldst_wr = tv[i].wr;
         i_ldst_wrdata = tv[i].wd;
         step();
         chk($sformatf("v%0d_pc", i), o_pc_rddata, tv[i].e_pc);
         chk($sformatf("v%0d_ld", i), o_ldst_rddata, tv[i].e_ld);
         chk($sformatf("v%0d_led", i), 16'(o_ledr), 16'(tv[i].e_led));
      end
      idle();

      // switch synchroniser: new value readable at the third edge, not before
      i_sw = 10'h2A5; step(); step();
      ld(16'hF002); step();
      chk("sw_2a5", o_ldst_rddata, 16'h02A5);
      i_sw = 10'h155;
      step(); chk("sw_old1", o_ldst_rddata, 16'h02A5);
      step(); chk("sw_old2", o_ldst_rddata, 16'h02A5);
      step(); chk("sw_new", o_ldst_rddata, 16'h0155);
      idle(); i_pc_addr = 16'hF002; i_pc_rd = 1'b1; step();
      chk("pc_mmio_sw", o_pc_rddata, 16'h0000);

      // counter counts every cycle; a store to CYCLES does not disturb it
      ld(16'hF004); step(); c0 = o_ldst_rddata;
      st(16'hF004, 16'h0000); step();
      ld(16'hF004); step();
      chk("cyc_nowr", o_ldst_rddata, c0 + 16'd2);

      // give outputs non-zero values, then reset between edges
      idle(); i_pc_addr = 16'h0020; i_pc_rd = 1'b1; step();
      chk("pre_rst_pc", o_pc_rddata, 16'h1234);
      idle(); #2;
      reset = 1'b1; #1;
      chk("rst_pc",  o_pc_rddata, 16'h0000);
      chk("rst_ld",  o_ldst_rddata, 16'h0000);
      chk("rst_led", 16'(o_ledr), 16'h0000);
      // store held during reset must not land in RAM
      st(16'h0040, 16'h5A5A); step();
      idle(); step();
      reset = 1'b0;
      ld(16'hF004); step();
      chk("cyc_first", o_ldst_rddata, 16'h0000);

      // run the counter up to the wrap point: edge k after release samples k-1
      idle();
      repeat (65534) @(posedge clk);
      #1;
      ld(16'hF004); step();
      chk("cyc_ffff", o_ldst_rddata, 16'hFFFF);
      step();
      chk("cyc_wrap", o_ldst_rddata, 16'h0000);
      ld(16'h0040); step();
      chk("rst_nowr", o_ldst_rddata == 16'h5A5A ? 16'h0001 : 16'h0000, 16'h0000);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
